// File: rtl/std_fp_smult_arbiter.sv
// Round-robin arbiter sharing one signed fixed-point multiplier among NUM_REQ go/done requesters.
// Each grant runs IDLE -> MUL -> TRUNC -> DONE, so one product completes every four cycles.
module std_fp_smult_arbiter #(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         go,
    input  logic [NUM_REQ*WIDTH-1:0]   left,
    input  logic [NUM_REQ*WIDTH-1:0]   right,
    output logic [WIDTH-1:0]           out,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshake: a requester raises go[i] and holds it until it sees done[i]; done is a
    // one-cycle pulse and go is only sampled in IDLE, so one request is never served twice.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_TRUNC = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    generate
        if (INT_WIDTH != WIDTH - FRAC_WIDTH) begin : g_bad_format
            $error("INT_WIDTH must equal WIDTH-FRAC_WIDTH");
        end
    endgenerate

    state_t                      r_state;
    logic [IDX_W-1:0]            r_last;
    logic [IDX_W-1:0]            r_sel;
    logic signed [WIDTH-1:0]     r_ltmp;
    logic signed [WIDTH-1:0]     r_rtmp;
    logic signed [2*WIDTH-1:0]   r_prod;

    logic [IDX_W-1:0]            w_idx;
    logic [IDX_W-1:0]            w_sel;
    logic                        w_found;
    logic                        w_unused;

    // First asserted go bit starting just after the last served requester.
    always_comb begin
        w_idx   = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(r_last) + k) % NUM_REQ);
            if (!w_found && go[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_unused  = ^{r_prod[2*WIDTH-1:WIDTH+FRAC_WIDTH], r_prod[FRAC_WIDTH-1:0]};
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_sel   <= '0;
            r_ltmp  <= '0;
            r_rtmp  <= '0;
            r_prod  <= '0;
            out     <= '0;
            done    <= '0;
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_ltmp  <= left[w_sel*WIDTH +: WIDTH];
                        r_rtmp  <= right[w_sel*WIDTH +: WIDTH];
                        r_sel   <= w_sel;
                        r_last  <= w_sel;
                        grant   <= NUM_REQ'(1) << w_sel;
                        busy    <= 1'b1;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod  <= r_ltmp * r_rtmp;
                    r_state <= S_TRUNC;
                end
                S_TRUNC: begin
                    // Dropping the low fraction bits floors toward -inf; high bits wrap.
                    out     <= r_prod[WIDTH+FRAC_WIDTH-1:FRAC_WIDTH];
                    done    <= NUM_REQ'(1) << r_sel;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= '0;
                    grant   <= '0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_std_fp_smult_arbiter.sv
// Directed bench for std_fp_smult_arbiter: Q16.16 products, round-robin order, reset abort.
module tb_std_fp_smult_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   go;
    logic [N*W-1:0] left;
    logic [N*W-1:0] right;
    logic [W-1:0]   out;
    logic [N-1:0]   done;
    logic [N-1:0]   grant;
    logic           busy;
    logic [1:0]     dbg_state;

    int n_cmp;
    int n_err;

    std_fp_smult_arbiter #(
        .WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16), .NUM_REQ(4)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
        .out(out), .done(done), .grant(grant), .busy(busy), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] l, input logic [W-1:0] r);
        left[i*W +: W]  = l;
        right[i*W +: W] = r;
    endtask

    // Wait up to 8 cycles for a done pulse; an expired bound counts as a failure.
    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done == '0 && k < 8) begin
            tick();
            k++;
        end
        if (done == '0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed no done expected done within 8 cycles", tag);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        go    = '0;
        left  = '0;
        right = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out", 64'(out), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // 1.5 * -2.0 = -3.0; left changed after grant must not matter
        set_ops(0, 32'h0001_8000, 32'hFFFE_0000);
        go = 4'b0001;
        tick();
        chk("t1_grant_mul", 64'(grant), 64'h1);
        chk("t1_busy_mul", 64'(busy), 64'h1);
        chk("t1_done_mul", 64'(done), 64'h0);
        set_ops(0, 32'h0000_0007, 32'hFFFE_0000);
        tick();
        chk("t1_grant_trunc", 64'(grant), 64'h1);
        chk("t1_done_trunc", 64'(done), 64'h0);
        tick();
        chk("t1_done", 64'(done), 64'h1);
        chk("t1_out", 64'(out), 64'hFFFD_0000);
        chk("t1_grant_done", 64'(grant), 64'h1);
        go = 4'b0000;
        tick();
        chk("t1_done_clr", 64'(done), 64'h0);
        chk("t1_grant_clr", 64'(grant), 64'h0);
        chk("t1_busy_clr", 64'(busy), 64'h0);
        chk("t1_out_hold", 64'(out), 64'hFFFD_0000);

        // 2^-16 * -0.5 floors to -2^-16
        set_ops(1, 32'h0000_0001, 32'hFFFF_8000);
        go = 4'b0010;
        tick(); tick(); tick();
        chk("trunc_done", 64'(done), 64'h2);
        chk("trunc_out", 64'(out), 64'hFFFF_FFFF);
        go = 4'b0000;
        tick();

        // 256 * 256 = 65536 wraps to 0
        set_ops(3, 32'h0100_0000, 32'h0100_0000);
        go = 4'b1000;
        tick(); tick(); tick();
        chk("wrap_done", 64'(done), 64'h8);
        chk("wrap_out", 64'(out), 64'h0);
        go = 4'b0000;
        tick();

        // Round-robin: requester i computes (i+1) * 2.0
        for (int i = 0; i < N; i++) set_ops(i, W'((i + 1) << 16), 32'h0002_0000);
        go = 4'b1111;
        for (int r = 0; r < N; r++) begin
            tick(); tick(); tick();
            chk($sformatf("rr%0d_done", r), 64'(done), 64'(1 << r));
            chk($sformatf("rr%0d_out", r), 64'(out), 64'((2 * r + 2) << 16));
            go[r] = 1'b0;
            tick();
        end
        chk("rr_idle_busy", 64'(busy), 64'h0);

        // Fairness: 0 and 2 keep requesting, 1 joins after the third completion
        begin
            int exp_seq[5] = '{0, 2, 0, 1, 2};
            go = 4'b0101;
            for (int s = 0; s < 5; s++) begin
                wait_done($sformatf("fair%0d_wait", s));
                chk($sformatf("fair%0d_done", s), 64'(done), 64'(1 << exp_seq[s]));
                chk($sformatf("fair%0d_grant", s), 64'(grant), 64'(1 << exp_seq[s]));
                if (s == 2) go[1] = 1'b1;
                if (s == 3) go[1] = 1'b0;
                tick();
            end
            go = 4'b0000;
            tick();
        end

        // Reset in TRUNC aborts; pointer returns so requester 2 is scanned from 0
        set_ops(0, 32'h0002_0000, 32'h0002_0000);
        go = 4'b0001;
        tick(); tick();
        reset = 1'b1;
        go    = 4'b0000;
        tick();
        chk("abort_done", 64'(done), 64'h0);
        chk("abort_out", 64'(out), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        chk("abort_grant", 64'(grant), 64'h0);
        reset = 1'b0;
        tick();
        chk("abort_no_late_done", 64'(done), 64'h0);
        set_ops(2, 32'h0003_0000, 32'h0001_0000);
        go = 4'b0100;
        tick();
        chk("post_rst_grant", 64'(grant), 64'h4);
        tick(); tick();
        chk("post_rst_done", 64'(done), 64'h4);
        chk("post_rst_out", 64'(out), 64'h0003_0000);
        go = 4'b0000;
        tick();

        // Pointer after reset-free run: last=2, so go=0011 picks 0 before 1
        set_ops(0, 32'hFFFF_0000, 32'hFFFF_0000);
        go = 4'b0011;
        tick();
        chk("wrap_ptr_grant", 64'(grant), 64'h1);
        tick(); tick();
        chk("neg_sq_out", 64'(out), 64'h0001_0000);
        go = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
